id_decode_queue: RTL and testbench
==================================

# id_decode_queue

Parametrised decode stage for the rv32i pipeline, sitting between fetch (IF) and execute (EX). It buffers up to DEPTH fetched instructions in a circular queue and fully decodes the queue head, including JAL/JALR/BRANCH, which the previous decode stage left undecoded. It registers the decoded result into the ID/EX slot under a valid/ready handshake. It supports hazard bubbles and pipeline flush, and replaces the single-entry `inst_store` holding scheme.

## Interface
Parameters:
- DEPTH, 4, queue entries; power of two, ≥2
- ORDER_W, 64, width of the retire-order tag carried alongside each instruction

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  discard queue contents and the output slot
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  queue can accept; equals (count < DEPTH) && rst_n
- in_inst  in  32  instruction word
- in_pc  in  32  instruction PC
- in_order  in  ORDER_W  order tag
- hazard_stall  in  1  from forwarding unit: hold head, issue bubble
- rs1_s, rs2_s  out  5 each  source registers of the queue head (combinational); 0 when the queue is empty or the field is unused by the opcode
- out_valid  out  1  ID/EX slot holds a real instruction
- out_ready  in  1  EX accepts the slot
- out_inst, out_pc  out  32 each  registered instruction and PC
- out_order  out  ORDER_W  registered order tag
- out_rs1, out_rs2, out_rd  out  5 each  register indices; unused fields are 0
- out_imm  out  32  sign-extended immediate selected by format (I/S/B/U/J)
- out_opclass  out  4  0 ILLEGAL, 1 LUI, 2 AUIPC, 3 JAL, 4 JALR, 5 BR, 6 LOAD, 7 STORE, 8 OPIMM, 9 OP
- out_funct3  out  3  inst[14:12]
- out_alt  out  1  inst[30] for OP, and for OPIMM with funct3=101; otherwise 0
- out_regf_we, out_mem_re, out_mem_we, out_illegal  out  1 each  control bits
- count  out  $clog2(DEPTH+1)  queue occupancy

## Operation
- Queue: write pointer, read pointer and count. Enqueue when in_valid && in_ready. Pointers wrap modulo DEPTH.
- Decode of the head is combinational.
  - Immediate format by opclass: I for JALR, LOAD and OPIMM; S for STORE; B for BR; U for LUI and AUIPC; J for JAL; 0 for ILLEGAL.
  - regf_we=1 for LUI, AUIPC, JAL, JALR, LOAD, OPIMM and OP.
  - rd is forced to 0 when regf_we=0.
  - Any unlisted opcode gives ILLEGAL: illegal=1, all enables 0.
- Advance condition: adv = !out_valid || out_ready.
- On an edge with adv:
  - If flush: slot becomes a bubble.
  - Else if hazard_stall or queue empty: slot becomes a bubble and the head is kept.
  - Else: the slot loads the decoded head and the head is popped.
- Without adv, the slot and the head hold.
- A bubble sets out_valid=0 and all out_* fields to 0.
- Flush has priority over everything:
  - count, pointers and out_valid go to 0.
  - A same-cycle enqueue is dropped.
- Simultaneous enqueue and pop: count unchanged. in_ready depends only on count, so a full queue refuses input even if a pop occurs in the same cycle.

## Timing
- Reset (rst_n low, asynchronous):
  - count=0, pointers=0, out_valid=0, all out_* fields=0.
  - in_ready=0 while reset is asserted, 1 on the first cycle after release.
  - rs1_s=rs2_s=0.
- Latency: an instruction enqueued at edge N into an empty queue, with out slot empty and no stall, is valid at out_* after edge N+1.
- Throughput: 1 instruction/cycle sustained when out_ready=1 and hazard_stall=0.
- hazard_stall is sampled only when adv=1. A stalled cycle inserts exactly one bubble and the same head is re-decoded next cycle.
- There is no combinational path from in_valid or out_ready to in_ready.

## Test plan
- Reset mid-stream, with 3 entries queued and out_valid=1: assert rst_n=0 -> count=0, out_valid=0, out_imm=0 immediately (asynchronous); after release, in_ready=1.
- Enqueue `addi x5,x1,-3` (0xFFD08293) into an empty queue -> one cycle later out_opclass=8, out_rd=5, out_rs1=1, out_rs2=0, out_imm=0xFFFFFFFD, out_regf_we=1.
- Fill with DEPTH=4 instructions while out_ready=0 -> count=4, in_ready=0. Raise out_ready -> out_order emits 4 tags in FIFO order, one per cycle; pointers wrap correctly on the 5th enqueue.
- Head `beq x1,x2,-8` (0xFE208CE3) -> out_opclass=5, out_imm=0xFFFFFFF8, out_regf_we=0, out_rd=0. JAL 0x008000EF -> out_opclass=3, out_imm=8, out_rd=1.
- hazard_stall=1 for 2 cycles with head `lw x3,4(x2)` -> rs1_s=2 throughout; 2 bubbles (out_valid=0); then the lw issues and count decrements by 1.
- flush with count=3 and in_valid=1 in the same cycle -> next cycle count=0 and out_valid=0; the incoming instruction is not queued.
- Opcode 0x7F -> out_illegal=1, out_opclass=0, all enables 0.

Source files
------------

// File: rtl/id_decode_queue.sv
// id_decode_queue: rv32i decode stage between IF and EX.
// Buffers up to DEPTH fetched instructions in a circular queue, fully decodes
// the queue head and registers the result into the ID/EX slot under a
// valid/ready handshake. Supports hazard bubbles and pipeline flush.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   flush                      drop queue contents and output slot
//   in_valid/in_ready          fetch handshake; in_inst, in_pc, in_order payload
//   hazard_stall               hold head, issue bubble
//   rs1_s, rs2_s               combinational source regs of queue head
//   out_valid/out_ready        ID/EX slot handshake; out_* registered decode
//   count                      queue occupancy
module id_decode_queue #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned ORDER_W = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [31:0]                  in_inst,
    input  logic [31:0]                  in_pc,
    input  logic [ORDER_W-1:0]           in_order,
    input  logic                         hazard_stall,
    output logic [4:0]                   rs1_s,
    output logic [4:0]                   rs2_s,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [31:0]                  out_inst,
    output logic [31:0]                  out_pc,
    output logic [ORDER_W-1:0]           out_order,
    output logic [4:0]                   out_rs1,
    output logic [4:0]                   out_rs2,
    output logic [4:0]                   out_rd,
    output logic [31:0]                  out_imm,
    output logic [3:0]                   out_opclass,
    output logic [2:0]                   out_funct3,
    output logic                         out_alt,
    output logic                         out_regf_we,
    output logic                         out_mem_re,
    output logic                         out_mem_we,
    output logic                         out_illegal,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    localparam logic [3:0] CLS_ILLEGAL = 4'd0;
    localparam logic [3:0] CLS_LUI     = 4'd1;
    localparam logic [3:0] CLS_AUIPC   = 4'd2;
    localparam logic [3:0] CLS_JAL     = 4'd3;
    localparam logic [3:0] CLS_JALR    = 4'd4;
    localparam logic [3:0] CLS_BR      = 4'd5;
    localparam logic [3:0] CLS_LOAD    = 4'd6;
    localparam logic [3:0] CLS_STORE   = 4'd7;
    localparam logic [3:0] CLS_OPIMM   = 4'd8;
    localparam logic [3:0] CLS_OP      = 4'd9;

    typedef struct packed {
        logic [31:0]        inst;
        logic [31:0]        pc;
        logic [ORDER_W-1:0] order;
        logic [4:0]         rs1;
        logic [4:0]         rs2;
        logic [4:0]         rd;
        logic [31:0]        imm;
        logic [3:0]         opclass;
        logic [2:0]         funct3;
        logic               alt;
        logic               regf_we;
        logic               mem_re;
        logic               mem_we;
        logic               illegal;
    } dec_t;

    // Queue storage (data only; occupancy is tracked by r_count)
    logic [31:0]        r_inst_q  [DEPTH];
    logic [31:0]        r_pc_q    [DEPTH];
    logic [ORDER_W-1:0] r_order_q [DEPTH];

    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             r_out_valid;
    dec_t             r_slot;

    logic        w_empty;
    logic        w_adv;
    logic        w_push;
    logic        w_pop;
    logic [31:0] w_hi;
    logic        w_use_rs1;
    logic        w_use_rs2;
    dec_t        w_dec;

    assign w_empty  = (r_count == '0);
    assign in_ready = (r_count < CNT_W'(DEPTH)) && rst_n;
    assign w_adv    = !r_out_valid || out_ready;
    assign w_push   = in_valid && in_ready && !flush;
    assign w_pop    = w_adv && !flush && !hazard_stall && !w_empty;
    assign w_hi     = r_inst_q[r_rptr];

    // Full combinational decode of the queue head
    always_comb begin
        w_dec         = '0;
        w_use_rs1     = 1'b0;
        w_use_rs2     = 1'b0;
        w_dec.inst    = w_hi;
        w_dec.pc      = r_pc_q[r_rptr];
        w_dec.order   = r_order_q[r_rptr];
        w_dec.funct3  = w_hi[14:12];
        case (w_hi[6:0])
            7'b0110111: begin
                w_dec.opclass = CLS_LUI;
                w_dec.imm     = {w_hi[31:12], 12'b0};
                w_dec.regf_we = 1'b1;
            end
            7'b0010111: begin
                w_dec.opclass = CLS_AUIPC;
                w_dec.imm     = {w_hi[31:12], 12'b0};
                w_dec.regf_we = 1'b1;
            end
            7'b1101111: begin
                w_dec.opclass = CLS_JAL;
                w_dec.imm     = {{11{w_hi[31]}}, w_hi[31], w_hi[19:12], w_hi[20], w_hi[30:21], 1'b0};
                w_dec.regf_we = 1'b1;
            end
            7'b1100111: begin
                w_dec.opclass = CLS_JALR;
                w_dec.imm     = {{20{w_hi[31]}}, w_hi[31:20]};
                w_dec.regf_we = 1'b1;
                w_use_rs1     = 1'b1;
            end
            7'b1100011: begin
                w_dec.opclass = CLS_BR;
                w_dec.imm     = {{19{w_hi[31]}}, w_hi[31], w_hi[7], w_hi[30:25], w_hi[11:8], 1'b0};
                w_use_rs1     = 1'b1;
                w_use_rs2     = 1'b1;
            end
            7'b0000011: begin
                w_dec.opclass = CLS_LOAD;
                w_dec.imm     = {{20{w_hi[31]}}, w_hi[31:20]};
                w_dec.regf_we = 1'b1;
                w_dec.mem_re  = 1'b1;
                w_use_rs1     = 1'b1;
            end
            7'b0100011: begin
                w_dec.opclass = CLS_STORE;
                w_dec.imm     = {{20{w_hi[31]}}, w_hi[31:25], w_hi[11:7]};
                w_dec.mem_we  = 1'b1;
                w_use_rs1     = 1'b1;
                w_use_rs2     = 1'b1;
            end
            7'b0010011: begin
                w_dec.opclass = CLS_OPIMM;
                w_dec.imm     = {{20{w_hi[31]}}, w_hi[31:20]};
                w_dec.regf_we = 1'b1;
                w_dec.alt     = (w_hi[14:12] == 3'b101) ? w_hi[30] : 1'b0;
                w_use_rs1     = 1'b1;
            end
            7'b0110011: begin
                w_dec.opclass = CLS_OP;
                w_dec.regf_we = 1'b1;
                w_dec.alt     = w_hi[30];
                w_use_rs1     = 1'b1;
                w_use_rs2     = 1'b1;
            end
            default: begin
                w_dec.opclass = CLS_ILLEGAL;
                w_dec.illegal = 1'b1;
            end
        endcase
        w_dec.rd  = w_dec.regf_we ? w_hi[11:7]  : 5'd0;
        w_dec.rs1 = w_use_rs1     ? w_hi[19:15] : 5'd0;
        w_dec.rs2 = w_use_rs2     ? w_hi[24:20] : 5'd0;
    end

    assign rs1_s = w_empty ? 5'd0 : w_dec.rs1;
    assign rs2_s = w_empty ? 5'd0 : w_dec.rs2;

    // Queue payload write; storage needs no reset since count gates reads
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_inst_q[r_wptr]  <= in_inst;
            r_pc_q[r_wptr]    <= in_pc;
            r_order_q[r_wptr] <= in_order;
        end
    end

    // Pointers, occupancy and the ID/EX slot; flush overrides everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_slot      <= '0;
        end else if (flush) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_slot      <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            if (w_adv) begin
                r_out_valid <= w_pop;
                r_slot      <= w_pop ? w_dec : '0;
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign out_inst    = r_slot.inst;
    assign out_pc      = r_slot.pc;
    assign out_order   = r_slot.order;
    assign out_rs1     = r_slot.rs1;
    assign out_rs2     = r_slot.rs2;
    assign out_rd      = r_slot.rd;
    assign out_imm     = r_slot.imm;
    assign out_opclass = r_slot.opclass;
    assign out_funct3  = r_slot.funct3;
    assign out_alt     = r_slot.alt;
    assign out_regf_we = r_slot.regf_we;
    assign out_mem_re  = r_slot.mem_re;
    assign out_mem_we  = r_slot.mem_we;
    assign out_illegal = r_slot.illegal;
    assign count       = r_count;

endmodule

// File: tb/tb_id_decode_queue.sv
// Testbench for id_decode_queue: directed vectors with hand-computed decode
// results pushed into a scoreboard; a negedge monitor pops and compares each
// accepted ID/EX slot. Control-path checks are made inline.
module tb_id_decode_queue;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned ORDER_W = 64;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [63:0] order;
        logic [3:0]  cls;
        logic [2:0]  f3;
        logic        alt;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        we;
        logic        re;
        logic        mwe;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_inst = '0;
    logic [31:0] in_pc = '0;
    logic [63:0] in_order = '0;
    logic        hazard_stall = 1'b0;
    logic [4:0]  rs1_s, rs2_s;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_inst, out_pc;
    logic [63:0] out_order;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic [31:0] out_imm;
    logic [3:0]  out_opclass;
    logic [2:0]  out_funct3;
    logic        out_alt, out_regf_we, out_mem_re, out_mem_we, out_illegal;
    logic [2:0]  count;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];

    id_decode_queue #(.DEPTH(DEPTH), .ORDER_W(ORDER_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
        .in_pc(in_pc), .in_order(in_order), .hazard_stall(hazard_stall),
        .rs1_s(rs1_s), .rs2_s(rs2_s), .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_pc(out_pc), .out_order(out_order),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm),
        .out_opclass(out_opclass), .out_funct3(out_funct3), .out_alt(out_alt),
        .out_regf_we(out_regf_we), .out_mem_re(out_mem_re), .out_mem_we(out_mem_we),
        .out_illegal(out_illegal), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_push(input logic [31:0] inst, input logic [31:0] pc, input logic [63:0] ord,
                            input logic [3:0] cls, input logic [2:0] f3, input logic alt,
                            input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [31:0] imm, input logic we, input logic re,
                            input logic mwe, input logic ill);
        exp_t e;
        e = '{inst, pc, ord, cls, f3, alt, rd, rs1, rs2, imm, we, re, mwe, ill};
        sb.push_back(e);
    endtask

    // Present one instruction for one clock edge
    task automatic send(input logic [31:0] inst, input logic [31:0] pc, input logic [63:0] ord);
        in_valid = 1'b1;
        in_inst  = inst;
        in_pc    = pc;
        in_order = ord;
        cyc();
        in_valid = 1'b0;
    endtask

    // Scoreboard monitor: each accepted slot must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            exp_t a, e;
            a = '{out_inst, out_pc, out_order, out_opclass, out_funct3, out_alt, out_rd,
                  out_rs1, out_rs2, out_imm, out_regf_we, out_mem_re, out_mem_we, out_illegal};
            n_checks++;
            if (sb.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_out: got %h expected nothing", a);
            end else begin
                e = sb.pop_front();
                if (a !== e) begin
                    n_errors++;
                    $display("FAIL slot_order_%0h: got %h expected %h", e.order, a, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #22;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_rs1_s", 64'(rs1_s), 64'd0);
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("rel_in_ready", 64'(in_ready), 64'd1);

        // addi x5,x1,-3: latency check plus scoreboard compare
        exp_push(32'hFFD08293, 32'h100, 64'h1, 4'd8, 3'd0, 1'b0, 5'd5, 5'd1, 5'd0,
                 32'hFFFFFFFD, 1'b1, 1'b0, 1'b0, 1'b0);
        send(32'hFFD08293, 32'h100, 64'h1);
        chk("lat_count_after_enq", 64'(count), 64'd1);
        chk("lat_not_yet_valid", 64'(out_valid), 64'd0);
        chk("lat_head_rs1_s", 64'(rs1_s), 64'd1);
        cyc();
        chk("lat_valid_n1", 64'(out_valid), 64'd1);
        chk("lat_count_popped", 64'(count), 64'd0);
        cyc(); cyc();

        // Back-to-back decode of each format, 1/cycle
        exp_push(32'hFE208CE3, 32'h200, 64'h10, 4'd5, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2,
                 32'hFFFFFFF8, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_push(32'h008000EF, 32'h204, 64'h11, 4'd3, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0,
                 32'h00000008, 1'b1, 1'b0, 1'b0, 1'b0);
        exp_push(32'h406283B3, 32'h208, 64'h12, 4'd9, 3'd0, 1'b1, 5'd7, 5'd5, 5'd6,
                 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0);
        exp_push(32'hFE612E23, 32'h20C, 64'h13, 4'd7, 3'd2, 1'b0, 5'd0, 5'd2, 5'd6,
                 32'hFFFFFFFC, 1'b0, 1'b0, 1'b1, 1'b0);
        exp_push(32'h12345537, 32'h210, 64'h14, 4'd1, 3'd5, 1'b0, 5'd10, 5'd0, 5'd0,
                 32'h12345000, 1'b1, 1'b0, 1'b0, 1'b0);
        exp_push(32'h40325213, 32'h214, 64'h15, 4'd8, 3'd5, 1'b1, 5'd4, 5'd4, 5'd0,
                 32'h00000403, 1'b1, 1'b0, 1'b0, 1'b0);
        exp_push(32'h0000007F, 32'h218, 64'h16, 4'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0,
                 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1);
        send(32'hFE208CE3, 32'h200, 64'h10);
        send(32'h008000EF, 32'h204, 64'h11);
        send(32'h406283B3, 32'h208, 64'h12);
        send(32'hFE612E23, 32'h20C, 64'h13);
        chk("tput_count", 64'(count), 64'd1);
        send(32'h12345537, 32'h210, 64'h14);
        send(32'h40325213, 32'h214, 64'h15);
        send(32'h0000007F, 32'h218, 64'h16);
        cyc(); cyc(); cyc();

        // Fill with out_ready low: first lands in slot, next four fill queue
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            exp_push(32'hFFD08293, 32'h300 + 32'(4*k), 64'hF000_0000_0000_0020 + 64'(k),
                     4'd8, 3'd0, 1'b0, 5'd5, 5'd1, 5'd0, 32'hFFFFFFFD, 1'b1, 1'b0, 1'b0, 1'b0);
            send(32'hFFD08293, 32'h300 + 32'(4*k), 64'hF000_0000_0000_0020 + 64'(k));
        end
        chk("full_count", 64'(count), 64'd4);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_out_valid", 64'(out_valid), 64'd1);
        send(32'h0000007F, 32'h3FC, 64'hDEAD);
        chk("full_refuses", 64'(count), 64'd4);
        out_ready = 1'b1;
        cyc(); cyc(); cyc(); cyc();
        chk("drain_count", 64'(count), 64'd0);
        chk("drain_last_valid", 64'(out_valid), 64'd1);
        cyc(); cyc();
        chk("drain_idle", 64'(out_valid), 64'd0);

        // Hazard stall: two bubbles, head held, then lw x3,4(x2) issues
        exp_push(32'h00412183, 32'h400, 64'h40, 4'd6, 3'd2, 1'b0, 5'd3, 5'd2, 5'd0,
                 32'h00000004, 1'b1, 1'b1, 1'b0, 1'b0);
        hazard_stall = 1'b1;
        send(32'h00412183, 32'h400, 64'h40);
        chk("hz_rs1_s_0", 64'(rs1_s), 64'd2);
        chk("hz_rs2_s_0", 64'(rs2_s), 64'd0);
        for (int k = 0; k < 2; k++) begin
            cyc();
            chk($sformatf("hz_bubble_%0d", k), 64'(out_valid), 64'd0);
            chk($sformatf("hz_count_%0d", k), 64'(count), 64'd1);
            chk($sformatf("hz_rs1_s_%0d", k + 1), 64'(rs1_s), 64'd2);
        end
        hazard_stall = 1'b0;
        cyc();
        chk("hz_issue_valid", 64'(out_valid), 64'd1);
        chk("hz_issue_count", 64'(count), 64'd0);
        chk("hz_rs1_s_empty", 64'(rs1_s), 64'd0);
        cyc(); cyc();

        // Flush with count=3 and a concurrent enqueue; nothing should issue
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) send(32'hFFD08293, 32'h500, 64'h50 + 64'(k));
        chk("fl_pre_count", 64'(count), 64'd3);
        chk("fl_pre_valid", 64'(out_valid), 64'd1);
        flush = 1'b1;
        send(32'h00412183, 32'h510, 64'h5F);
        flush = 1'b0;
        chk("fl_count", 64'(count), 64'd0);
        chk("fl_out_valid", 64'(out_valid), 64'd0);
        chk("fl_out_imm", 64'(out_imm), 64'd0);
        out_ready = 1'b1;
        cyc(); cyc();
        chk("fl_dropped", 64'(out_valid), 64'd0);

        // Asynchronous reset mid-stream with 3 entries queued and slot valid
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) send(32'hFFD08293, 32'h600, 64'h60 + 64'(k));
        chk("ar_pre_count", 64'(count), 64'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_count", 64'(count), 64'd0);
        chk("ar_out_valid", 64'(out_valid), 64'd0);
        chk("ar_out_imm", 64'(out_imm), 64'd0);
        chk("ar_in_ready", 64'(in_ready), 64'd0);
        cyc();
        rst_n = 1'b1;
        out_ready = 1'b1;
        cyc();
        chk("ar_in_ready_rel", 64'(in_ready), 64'd1);
        chk("ar_stays_empty", 64'(out_valid), 64'd0);

        for (int i = 0; i < 20 && sb.size() > 0; i++) cyc();
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
